dmem_ctrl: RTL



---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_lane_align.sv | 44 ++++
 rtl/dmem_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressed data memory controller:
// RV32 load/store funct3 codes, FSM states and access-size decode.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BEAT2,
    RESP
  } state_t;

  // Number of bytes touched by an access (illegal codes decode as a word).
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enable/data shift and load
// extract/extend over a two-word {hi, lo} window, shared by both beats.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rd_lo,
  input  logic [31:0] rd_hi,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wd_lo,
  output logic [31:0] wd_hi,
  output logic [31:0] rdata
);

  logic [3:0]  bmask;
  logic [31:0] rword;

  always_comb begin
    case (access_bytes(funct3))
      3'd1:    bmask = 4'b0001;
      3'd2:    bmask = 4'b0011;
      default: bmask = 4'b1111;
    endcase

    // Bytes shifted past lane 3 land in the upper word for the second beat.
    {be_hi, be_lo} = {4'b0000, bmask} << lane;
    {wd_hi, wd_lo} = {32'h0, wdata} << {lane, 3'b000};

    rword = 32'({rd_hi, rd_lo} >> {lane, 3'b000});

    case (funct3)
      F3_B:    rdata = {{24{rword[7]}}, rword[7:0]};
      F3_BU:   rdata = {24'h0, rword[7:0]};
      F3_H:    rdata = {{16{rword[15]}}, rword[15:0]};
      F3_HU:   rdata = {16'h0, rword[15:0]};
      F3_W:    rdata = rword;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed RV32 data memory with valid/ready request and registered
// response. Define DMEM_MISALIGN_EN to allow misaligned and word-crossing access.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned WORDS = 2 ** (ADDR_W - 2);
`ifdef DMEM_MISALIGN_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  logic [DATA_W-1:0] mem [WORDS];

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [31:0]       wdata_q, lo_q, rdata_q;
  logic              err_q;

  logic [ADDR_W-3:0] idx, idx_q, idx_nx, wr_idx;
  logic [1:0]        lane;
  logic [2:0]        req_nbytes;
  logic              req_illegal, req_misal, req_cross, req_err;
  logic              in_beat2;

  logic [1:0]  al_lane;
  logic [2:0]  al_f3;
  logic [31:0] al_wdata, al_lo, al_hi, al_rdata;
  logic [3:0]  be_lo, be_hi, wr_be;
  logic [31:0] wd_lo, wd_hi, wr_data;
  logic        wr_en;

  assign idx        = req_addr[ADDR_W-1:2];
  assign lane       = req_addr[1:0];
  assign idx_q      = addr_q[ADDR_W-1:2];
  assign idx_nx     = idx_q + 1'b1;
  assign req_nbytes = access_bytes(req_funct3);
  assign in_beat2   = (state == BEAT2);

  assign req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
  assign req_misal   = ((req_nbytes == 3'd2) && lane[0]) ||
                       ((req_nbytes == 3'd4) && (lane != 2'b00));
  assign req_cross   = (({1'b0, lane} + req_nbytes) > 3'd4);
  assign req_err     = req_illegal || (!MISALIGN_EN && req_misal);

  // The second beat replays the latched request against the next word,
  // with the first-beat word held in lo_q for the load merge.
  assign al_lane  = in_beat2 ? addr_q[1:0] : lane;
  assign al_f3    = in_beat2 ? f3_q : req_funct3;
  assign al_wdata = in_beat2 ? wdata_q : req_wdata;
  assign al_lo    = in_beat2 ? lo_q : mem[idx];
  assign al_hi    = in_beat2 ? mem[idx_nx] : '0;

  dmem_lane_align u_align (
    .lane   (al_lane),
    .funct3 (al_f3),
    .wdata  (al_wdata),
    .rd_lo  (al_lo),
    .rd_hi  (al_hi),
    .be_lo  (be_lo),
    .be_hi  (be_hi),
    .wd_lo  (wd_lo),
    .wd_hi  (wd_hi),
    .rdata  (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    wr_idx   = idx;
    wr_be    = be_lo;
    wr_data  = wd_lo;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_nx = RESP;
          end else if (MISALIGN_EN && req_cross) begin
            state_nx = BEAT2;
            wr_en    = req_we;
          end else begin
            state_nx = RESP;
            wr_en    = req_we;
          end
        end
      end
      BEAT2: begin
        state_nx = RESP;
        wr_en    = we_q;
        wr_idx   = idx_nx;
        wr_be    = be_hi;
        wr_data  = wd_hi;
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (rst) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      addr_q  <= req_addr;
      f3_q    <= req_funct3;
      we_q    <= req_we;
      wdata_q <= req_wdata;
      lo_q    <= mem[idx];
      err_q   <= req_err;
      rdata_q <= (req_err || req_we) ? '0 : al_rdata;
    end else if (state == BEAT2) begin
      err_q   <= 1'b0;
      rdata_q <= we_q ? '0 : al_rdata;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
